// File: rtl/saa_envelope_gen.sv
// saa_envelope_gen
// Envelope generator for the SAA sound path, with a parametrised level width.
// A level counter steps on a selected tick and walks through one or two
// shape phases (attack/decay). Single shapes park in DONE at the end of a
// cycle. Repeat shapes restart. A config written while the envelope runs is
// held in a shadow register and loaded at the next end of cycle.
//
// Ports:
//   clk_sys     system clock
//   rst_n       asynchronous active-low reset
//   ce          clock enable for int_tick
//   cfg_wr      control register write strobe
//   cfg_data    [7]=enable [5]=clk_src(1=ext) [4]=res(coarse) [3:1]=shape [0]=invert right
//   int_tick    internal step strobe, qualified by ce
//   ext_tick    external step strobe, not qualified by ce
//   env_l       left envelope level (registered)
//   env_r       right envelope level (registered, optionally inverted)
//   pending     shadow config waiting for the end of the current cycle
//   cycle_done  one-cycle pulse after each completed envelope cycle
//   active      enabled and not parked in DONE (registered)
module saa_envelope_gen #(
  parameter int LEVEL_W = 4
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               cfg_wr,
  input  logic [7:0]         cfg_data,
  input  logic               int_tick,
  input  logic               ext_tick,
  output logic [LEVEL_W-1:0] env_l,
  output logic [LEVEL_W-1:0] env_r,
  output logic               pending,
  output logic               cycle_done,
  output logic               active
);

  localparam logic [LEVEL_W-1:0] MAX = '1;

  logic [7:0]         cfg_q, cfg_d;
  logic [7:0]         shadow_q, shadow_d;
  logic [LEVEL_W-1:0] cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic               done_q, done_d;
  logic               pend_d;

  logic               en, src, res, inv;
  logic [2:0]         shape;
  logic [LEVEL_W-1:0] mask, step, m_lvl, lvl, lvl_r;
  logic               tick, eop, last_phase, eoc, wr_now;
  logic               unused_bits;

  assign en    = cfg_q[7];
  assign src   = cfg_q[5];
  assign res   = cfg_q[4];
  assign shape = cfg_q[3:1];
  assign inv   = cfg_q[0];
  assign unused_bits = cfg_q[6];

  // Coarse resolution masks the counter LSB and steps by two.
  assign mask  = {{(LEVEL_W-1){1'b0}}, res};
  assign step  = res ? LEVEL_W'(2) : LEVEL_W'(1);
  assign m_lvl = MAX & ~mask;

  function automatic logic [LEVEL_W-1:0] shape_level(
    input logic [2:0]         shp,
    input logic               ph,
    input logic [LEVEL_W-1:0] cnt,
    input logic [LEVEL_W-1:0] msk
  );
    logic [LEVEL_W-1:0] a_lvl, d_lvl;
    a_lvl = cnt & ~msk;
    d_lvl = (MAX - cnt) & ~msk;
    case (shp)
      3'd0:       shape_level = '0;
      3'd1:       shape_level = MAX & ~msk;
      3'd2, 3'd3: shape_level = d_lvl;
      3'd4, 3'd5: shape_level = ph ? d_lvl : a_lvl;
      default:    shape_level = a_lvl;
    endcase
  endfunction

  assign tick       = (src ? ext_tick : (int_tick & ce)) & en & ~done_q;
  assign eop        = ((cnt_q | mask) == MAX);
  // Only shapes 4/5 have a second (decay) phase.
  assign last_phase = (shape[2:1] != 2'b10) | phase_q;
  assign eoc        = tick & eop & last_phase;
  // Writes that cannot disturb a running envelope take effect at once.
  assign wr_now     = cfg_wr & (~en | ~cfg_data[7] | done_q);

  always_comb begin
    cfg_d    = cfg_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    done_d   = done_q;
    pend_d   = pending;
    if (tick) begin
      cnt_d = cnt_q + step;
      if (eop && !last_phase) begin
        phase_d = 1'b1;
        cnt_d   = '0;
      end else if (eoc) begin
        if (pending) begin
          cfg_d   = shadow_q;
          cnt_d   = '0;
          phase_d = 1'b0;
          done_d  = 1'b0;
          pend_d  = 1'b0;
        end else if (shape[0]) begin
          cnt_d   = '0;
          phase_d = 1'b0;
        end else begin
          done_d  = 1'b1;
          cnt_d   = MAX;
        end
      end
    end
    // A write landing on the end-of-cycle tick bypasses the shadow.
    if (cfg_wr) begin
      if (wr_now || eoc) begin
        cfg_d   = cfg_data;
        cnt_d   = '0;
        phase_d = 1'b0;
        done_d  = 1'b0;
        pend_d  = 1'b0;
      end else begin
        shadow_d = cfg_data;
        pend_d   = 1'b1;
      end
    end
  end

  assign lvl   = (en && !done_q) ? shape_level(shape, phase_q, cnt_q, mask) : '0;
  assign lvl_r = !en ? '0 : (inv ? (m_lvl - lvl) : lvl);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q      <= '0;
      shadow_q   <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      done_q     <= 1'b0;
      pending    <= 1'b0;
      cycle_done <= 1'b0;
      env_l      <= '0;
      env_r      <= '0;
      active     <= 1'b0;
    end else begin
      cfg_q      <= cfg_d;
      shadow_q   <= shadow_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      done_q     <= done_d;
      pending    <= pend_d;
      // Output stage: levels and active lag the envelope state by one cycle.
      cycle_done <= eoc;
      env_l      <= lvl;
      env_r      <= lvl_r;
      active     <= en & ~done_q;
    end
  end

endmodule

// File: tb/tb_saa_envelope_gen.sv
module tb_saa_envelope_gen;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       ce, cfg_wr, int_tick, ext_tick;
  logic [7:0] cfg_data;
  logic [3:0] env_l, env_r;
  logic       pending, cycle_done, active;

  logic       ce6, cfg_wr6, int_tick6, ext_tick6;
  logic [7:0] cfg_data6;
  logic [5:0] env_l6, env_r6;
  logic       pending6, cycle_done6, active6;

  saa_envelope_gen #(.LEVEL_W(4)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .ce(ce), .cfg_wr(cfg_wr), .cfg_data(cfg_data),
    .int_tick(int_tick), .ext_tick(ext_tick), .env_l(env_l), .env_r(env_r),
    .pending(pending), .cycle_done(cycle_done), .active(active)
  );

  saa_envelope_gen #(.LEVEL_W(6)) dut6 (
    .clk_sys(clk_sys), .rst_n(rst_n), .ce(ce6), .cfg_wr(cfg_wr6), .cfg_data(cfg_data6),
    .int_tick(int_tick6), .ext_tick(ext_tick6), .env_l(env_l6), .env_r(env_r6),
    .pending(pending6), .cycle_done(cycle_done6), .active(active6)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic int get_sig(input int sig);
    case (sig)
      0:       return int'(env_l);
      1:       return int'(env_r);
      2:       return int'(pending);
      3:       return int'(cycle_done);
      4:       return int'(active);
      5:       return int'(env_l6);
      6:       return int'(cycle_done6);
      default: return int'(env_r6);
    endcase
  endfunction

  // Monitor: compares every expectation that falls due in the current cycle.
  always @(negedge clk_sys) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        int act;
        act = get_sig(sb[i].sig);
        n_cmp++;
        if (sb[i].cyc < cyc) begin
          n_fail++;
          $display("FAIL %s: missed sample at cycle %0d (now %0d)", sb[i].name, sb[i].cyc, cyc);
        end else if (act != sb[i].val) begin
          n_fail++;
          $display("FAIL %s: got %0d expected %0d (cycle %0d)", sb[i].name, act, sb[i].val, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic chk(input int sig, input int val, input int dly, input string name);
    exp_t e;
    e.cyc = cyc + dly; e.sig = sig; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic chk_env(input string tag, input int k, input int l, input int r, input int cd);
    chk(0, l, 1, $sformatf("%s_k%0d_env_l", tag, k));
    chk(1, r, 1, $sformatf("%s_k%0d_env_r", tag, k));
    chk(3, cd, 0, $sformatf("%s_k%0d_cycle_done", tag, k));
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
    cfg_wr = 1'b0; int_tick = 1'b0; ext_tick = 1'b0;
    cfg_wr6 = 1'b0; int_tick6 = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    cfg_data = d; cfg_wr = 1'b1;
    step();
  endtask

  task automatic tick_i();
    int_tick = 1'b1; ce = 1'b1;
    step();
  endtask

  initial begin
    int l;
    rst_n = 1'b1; ce = 1'b0; cfg_wr = 1'b0; cfg_data = '0; int_tick = 1'b0; ext_tick = 1'b0;
    ce6 = 1'b0; cfg_wr6 = 1'b0; cfg_data6 = '0; int_tick6 = 1'b0; ext_tick6 = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1 rst_n = 1'b1;
    chk(0, 0, 0, "rst_env_l"); chk(1, 0, 0, "rst_env_r"); chk(2, 0, 0, "rst_pending");
    chk(3, 0, 0, "rst_cycle_done"); chk(4, 0, 0, "rst_active"); chk(5, 0, 0, "rst_env_l6");

    // Shape 2 fine, immediate load
    wr(8'h84);
    chk(0, 15, 1, "t1_env_l_load"); chk(4, 1, 1, "t1_active"); chk(2, 0, 0, "t1_pending");
    for (int k = 1; k <= 16; k++) begin
      tick_i();
      l = (k < 16) ? 15 - k : 0;
      chk_env("t1", k, l, l, (k == 16) ? 1 : 0);
    end
    chk(4, 0, 1, "t1_active_done");
    tick_i();
    chk_env("t1_hold", 0, 0, 0, 0);

    // Shape 7 coarse, repeating
    wr(8'h9E);
    chk(0, 0, 1, "t2_env_l_load"); chk(4, 1, 1, "t2_active");
    for (int k = 1; k <= 16; k++) begin
      tick_i();
      l = (2 * k) % 16;
      chk_env("t2", k, l, l, (k % 8 == 0) ? 1 : 0);
    end

    // Triangle with inverted right channel
    wr(8'h00);
    chk(0, 0, 1, "t3_off_env_l"); chk(1, 0, 1, "t3_off_env_r"); chk(4, 0, 1, "t3_off_active");
    wr(8'h8B);
    chk(0, 0, 1, "t3_env_l_load"); chk(1, 15, 1, "t3_env_r_load");
    for (int k = 1; k <= 32; k++) begin
      tick_i();
      l = (k < 16) ? k : ((k < 32) ? 31 - k : 0);
      chk_env("t3", k, l, 15 - l, (k == 32) ? 1 : 0);
    end
    for (int k = 1; k <= 5; k++) begin
      tick_i();
      chk_env("t3b", k, k, 15 - k, 0);
    end
    step();
    step();
    // Asynchronous reset in the middle of the triangle
    rst_n = 1'b0;
    chk(0, 0, 0, "arst_env_l"); chk(1, 0, 0, "arst_env_r"); chk(4, 0, 0, "arst_active");
    chk(2, 0, 0, "arst_pending"); chk(3, 0, 0, "arst_cycle_done");
    @(negedge clk_sys);
    @(posedge clk_sys);
    #1 rst_n = 1'b1;

    // Pending config: shape 3 running, shape 6 queued
    wr(8'h86);
    chk(0, 15, 1, "t4_env_l_load"); chk(2, 0, 0, "t4_pending_load");
    for (int k = 1; k <= 16; k++) begin
      if (k == 5) begin
        cfg_data = 8'h8C; cfg_wr = 1'b1;
      end
      tick_i();
      l = (k < 16) ? 15 - k : 0;
      chk_env("t4", k, l, l, (k == 16) ? 1 : 0);
      chk(2, (k >= 5 && k < 16) ? 1 : 0, 0, $sformatf("t4_k%0d_pending", k));
    end
    for (int k = 1; k <= 16; k++) begin
      tick_i();
      l = (k < 16) ? k : 0;
      chk_env("t4s6", k, l, l, (k == 16) ? 1 : 0);
    end
    chk(4, 0, 1, "t4s6_active_done");

    // Last shadow write wins
    wr(8'h86);
    chk(0, 15, 1, "t5_env_l_load"); chk(4, 1, 1, "t5_active");
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        cfg_data = 8'h8C; cfg_wr = 1'b1;
      end
      if (k == 6) begin
        cfg_data = 8'h9E; cfg_wr = 1'b1;
      end
      tick_i();
      l = (k < 16) ? 15 - k : 0;
      chk_env("t5", k, l, l, (k == 16) ? 1 : 0);
      chk(2, (k >= 3 && k < 16) ? 1 : 0, 0, $sformatf("t5_k%0d_pending", k));
    end
    for (int k = 1; k <= 7; k++) begin
      tick_i();
      chk_env("t5s7", k, 2 * k, 2 * k, 0);
    end

    // Write coinciding with the end-of-cycle tick
    cfg_data = 8'h84; cfg_wr = 1'b1;
    tick_i();
    chk_env("t6_bypass", 8, 15, 15, 1);
    chk(2, 0, 0, "t6_bypass_pending");
    tick_i();
    chk_env("t6_after", 1, 14, 14, 0);

    // External clock source and ce qualification
    wr(8'h00);
    chk(0, 0, 1, "t7_off_env_l");
    wr(8'hAE);
    chk(0, 0, 1, "t7_ext_load"); chk(4, 1, 1, "t7_ext_active");
    tick_i();
    chk(0, 0, 1, "t7_int_ignored");
    ext_tick = 1'b1; ce = 1'b0;
    step();
    chk(0, 1, 1, "t7_ext_tick1");
    ext_tick = 1'b1; ce = 1'b0;
    step();
    chk(0, 2, 1, "t7_ext_tick2");
    wr(8'h00);
    wr(8'h8E);
    chk(0, 0, 1, "t7_int_load");
    int_tick = 1'b1; ce = 1'b0;
    step();
    chk(0, 0, 1, "t7_int_ce0_ignored");
    tick_i();
    chk(0, 1, 1, "t7_int_ce1");
    ext_tick = 1'b1; ce = 1'b1;
    step();
    chk(0, 1, 1, "t7_ext_ignored");

    // LEVEL_W=6, shape 2 fine
    cfg_data6 = 8'h84; cfg_wr6 = 1'b1;
    step();
    chk(5, 63, 1, "w6_env_l_load");
    for (int k = 1; k <= 64; k++) begin
      int_tick6 = 1'b1; ce6 = 1'b1;
      step();
      l = (k < 64) ? 63 - k : 0;
      chk(5, l, 1, $sformatf("w6_k%0d_env_l", k));
      chk(7, l, 1, $sformatf("w6_k%0d_env_r", k));
      chk(6, (k == 64) ? 1 : 0, 0, $sformatf("w6_k%0d_cycle_done", k));
    end

    for (int i = 0; i < 5 && sb.size() != 0; i++) step();
    while (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: never sampled (due cycle %0d)", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
